// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative radix-2 multiply/divide unit with HI/LO, madd and Req abort
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] gpr_rs,
    input  logic [WIDTH-1:0] gpr_rt,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   rs_q, rs_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               is_madd_q, is_madd_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               dz_q, dz_d;

    logic               op_launch, op_signed, op_div;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] prod_signed, madd_sum;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_launch = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) || (MDUOp == OP_DIV) ||
                       (MDUOp == OP_DIVU) || (MDUOp == OP_MADD);
    assign op_signed = (MDUOp == OP_MULT) || (MDUOp == OP_DIV) || (MDUOp == OP_MADD);
    assign op_div    = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
    assign rs_neg    = op_signed & gpr_rs[WIDTH-1];
    assign rt_neg    = op_signed & gpr_rt[WIDTH-1];
    assign rs_mag    = rs_neg ? -gpr_rs : gpr_rs;
    assign rt_mag    = rt_neg ? -gpr_rt : gpr_rt;

    // Multiply: acc holds {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: acc holds {remainder, dividend/quotient}; remainder < divisor keeps diff in WIDTH bits
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opb_q;
    assign div_step  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign prod_signed = neg_lo_q ? -acc_q : acc_q;
    assign madd_sum    = {hi_q, lo_q} + prod_signed;
    assign quo_fix     = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix     = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        rs_d      = rs_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        is_madd_d = is_madd_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: begin
                if (!Req) begin
                    if (start && op_launch) begin
                        state_d   = S_RUN;
                        cnt_d     = CNT_W'(WIDTH);
                        acc_d     = {{WIDTH{1'b0}}, rs_mag};
                        opb_d     = rt_mag;
                        rs_d      = gpr_rs;
                        is_div_d  = op_div;
                        is_madd_d = (MDUOp == OP_MADD);
                        neg_lo_d  = rs_neg ^ rt_neg;
                        neg_hi_d  = rs_neg;
                        dz_d      = op_div && (gpr_rt == '0);
                    end
                    if (MDUOp == OP_MTHI) hi_d = gpr_rs;
                    if (MDUOp == OP_MTLO) lo_d = gpr_rs;
                end
            end
            S_RUN: begin
                if (Req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = is_div_q ? div_step : mul_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!Req) begin
                    if (!is_div_q) begin
                        {hi_d, lo_d} = is_madd_q ? madd_sum : prod_signed;
                    end else if (dz_q) begin
                        hi_d = rs_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            rs_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            is_madd_q <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            rs_q      <= rs_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            is_madd_q <= is_madd_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            dz_q      <= dz_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized and directed self-checking bench for mdu_iter
module tb_mdu_iter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         Req = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   MDUOp = 3'd0;
    logic [W-1:0] gpr_rs = '0;
    logic [W-1:0] gpr_rt = '0;
    logic         busy;
    logic [W-1:0] HI, LO;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .Req(Req), .MDUOp(MDUOp),
        .gpr_rs(gpr_rs), .gpr_rt(gpr_rt), .start(start),
        .busy(busy), .HI(HI), .LO(LO)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result {HI,LO} from plain arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [63:0] hilo);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = hilo;
        case (op)
            3'd1: r = sa * sb;
            3'd2: r = {32'b0, a} * {32'b0, b};
            3'd7: r = hilo + 64'(sa * sb);
            3'd3: if (b == 0) r = {a, 32'hFFFFFFFF};
                  else r = {32'(sa % sb), 32'(sa / sb)};
            3'd4: if (b == 0) r = {a, 32'hFFFFFFFF};
                  else r = {a % b, a / b};
            default: r = hilo;
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] exp;
        int n;
        exp = ref_result(op, a, b, {m_hi, m_lo});
        MDUOp = op; gpr_rs = a; gpr_rt = b; start = 1'b1;
        tick();
        start = 1'b0; MDUOp = 3'd0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check_eq($sformatf("busy_cycles op%0d", op), 64'(n), 64'd33);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        check_eq($sformatf("hi op%0d %h/%h", op, a, b), 64'(HI), 64'(m_hi));
        check_eq($sformatf("lo op%0d %h/%h", op, a, b), 64'(LO), 64'(m_lo));
    endtask

    task automatic move_to(input logic [2:0] op, input logic [W-1:0] v);
        MDUOp = op; gpr_rs = v;
        tick();
        MDUOp = 3'd0;
        if (op == 3'd5) m_hi = v; else m_lo = v;
        check_eq("mt_hi", 64'(HI), 64'(m_hi));
        check_eq("mt_lo", 64'(LO), 64'(m_lo));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp;
        logic [2:0]  op;
        logic [W-1:0] a, b;
        int n;

        tick();
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_hi", 64'(HI), 64'd0);
        check_eq("reset_lo", 64'(LO), 64'd0);
        reset = 1'b1;
        tick();

        run_op(3'd1, 32'hFFFFFFFE, 32'd3);
        check_eq("mult_hi_const", 64'(HI), 64'hFFFFFFFF);
        check_eq("mult_lo_const", 64'(LO), 64'hFFFFFFFA);
        run_op(3'd2, 32'hFFFFFFFE, 32'd3);
        check_eq("multu_hi_const", 64'(HI), 64'h2);
        run_op(3'd4, 32'd100, 32'd7);
        check_eq("divu_lo_const", 64'(LO), 64'd14);
        check_eq("divu_hi_const", 64'(HI), 64'd2);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2);
        check_eq("div_lo_const", 64'(LO), 64'hFFFFFFFD);
        check_eq("div_hi_const", 64'(HI), 64'hFFFFFFFF);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        check_eq("ovf_lo_const", 64'(LO), 64'h80000000);
        check_eq("ovf_hi_const", 64'(HI), 64'h0);
        run_op(3'd3, 32'h1234, 32'd0);
        check_eq("dz_div_lo", 64'(LO), 64'hFFFFFFFF);
        check_eq("dz_div_hi", 64'(HI), 64'h1234);
        run_op(3'd4, 32'h1234, 32'd0);
        check_eq("dz_divu_lo", 64'(LO), 64'hFFFFFFFF);

        move_to(3'd5, 32'd5);
        move_to(3'd6, 32'd7);
        run_op(3'd7, 32'hFFFFFFFF, 32'd2);
        check_eq("madd_hi_const", 64'(HI), 64'd5);
        check_eq("madd_lo_const", 64'(LO), 64'd5);

        // mtlo and a second start while busy must not disturb the op in flight
        exp = ref_result(3'd1, 32'h00012345, 32'hFFFF0001, {m_hi, m_lo});
        MDUOp = 3'd1; gpr_rs = 32'h00012345; gpr_rt = 32'hFFFF0001; start = 1'b1;
        tick();
        start = 1'b0; MDUOp = 3'd0;
        repeat (3) tick();
        MDUOp = 3'd6; gpr_rs = 32'hDEADBEEF;
        tick();
        check_eq("mtlo_busy_lo", 64'(LO), 64'(m_lo));
        MDUOp = 3'd2; gpr_rs = 32'd9; gpr_rt = 32'd9; start = 1'b1;
        tick();
        start = 1'b0; MDUOp = 3'd0;
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        check_eq("busy_ops_cycles", 64'(n), 64'd28);
        m_hi = exp[63:32]; m_lo = exp[31:0];
        check_eq("busy_ops_hi", 64'(HI), 64'(m_hi));
        check_eq("busy_ops_lo", 64'(LO), 64'(m_lo));

        // Req abort mid-run
        MDUOp = 3'd1; gpr_rs = 32'd1000; gpr_rt = 32'd1000; start = 1'b1;
        tick();
        start = 1'b0; MDUOp = 3'd0;
        repeat (9) tick();
        Req = 1'b1;
        tick();
        Req = 1'b0;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_hi", 64'(HI), 64'(m_hi));
        repeat (40) tick();
        check_eq("abort_late_hi", 64'(HI), 64'(m_hi));
        check_eq("abort_late_lo", 64'(LO), 64'(m_lo));

        // Req coinciding with the commit edge
        MDUOp = 3'd2; gpr_rs = 32'd77; gpr_rt = 32'd88; start = 1'b1;
        tick();
        start = 1'b0; MDUOp = 3'd0;
        repeat (32) tick();
        check_eq("fix_busy_before", 64'(busy), 64'd1);
        Req = 1'b1;
        tick();
        Req = 1'b0;
        check_eq("fix_abort_busy", 64'(busy), 64'd0);
        check_eq("fix_abort_hi", 64'(HI), 64'(m_hi));
        check_eq("fix_abort_lo", 64'(LO), 64'(m_lo));

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 6))
                0: op = 3'd1;
                1: op = 3'd2;
                2: op = 3'd3;
                3: op = 3'd4;
                4: op = 3'd7;
                5: op = 3'd5;
                default: op = 3'd6;
            endcase
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
            if (op == 3'd5 || op == 3'd6) move_to(op, a);
            else run_op(op, a, b);
        end

        // asynchronous reset in the middle of a divide
        MDUOp = 3'd3; gpr_rs = 32'd12345; gpr_rt = 32'd7; start = 1'b1;
        tick();
        start = 1'b0; MDUOp = 3'd0;
        repeat (14) tick();
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_busy", 64'(busy), 64'd0);
        check_eq("async_rst_hi", 64'(HI), 64'd0);
        check_eq("async_rst_lo", 64'(LO), 64'd0);
        m_hi = '0; m_lo = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_eq("post_rst_hi", 64'(HI), 64'hFFFFFFFE);
        check_eq("post_rst_lo", 64'(LO), 64'h00000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit; successor to the fixed-latency behavioural MDU.
- Real radix-2 engine: shift-add multiply, restoring divide, one iteration per cycle.
- Adds multiply-accumulate, a defined divide-by-zero result and exception abort via Req.
- Sits in the EX stage. The hazard unit stalls on busy or start; HI/LO feed mfhi/mflo.

Parameters:
- WIDTH, 32, operand and HI/LO width (≥4, even).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Req  input  1  exception/interrupt flush. When high, it aborts the in-flight op and blocks all writes that edge.
- MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd (signed accumulate).
- gpr_rs  input  WIDTH  operand A / dividend / mthi-mtlo source.
- gpr_rt  input  WIDTH  operand B / divisor.
- start  input  1  launch the op on MDUOp (valid for ops 1-4, 7).
- busy  output  1  engine active.
- HI  output  WIDTH  architectural HI.
- LO  output  WIDTH  architectural LO.

Behaviour:
- Reset (reset==0, async): state=IDLE, busy=0, HI=0, LO=0, counter=0, internal regs=0. Takes effect immediately, including mid-operation; the op is discarded.
- States:
  - IDLE: waits for start.
  - RUN: WIDTH iterations.
  - FIX: sign fix-up and commit.
- IDLE, start=1, Req=0, op in {1,2,3,4,7}:
  - Latch |A| and |B| (magnitudes only for signed ops 1, 3, 7) and the result-sign flags.
  - Go to RUN with counter=WIDTH; busy=1 from this edge.
- RUN: one iteration per edge, counter decrements; at counter==1 go to FIX.
  - Multiply: 2*WIDTH-bit product register, conditional add of the multiplicand, shift right.
  - Divide: remainder/quotient shift-left, trial subtract, restore on negative.
- FIX:
  - Apply the sign fix-up and write HI/LO.
  - busy=0 and state=IDLE at the same edge.
- Latency: start seen at edge E0; HI/LO updated and busy falls at edge E(WIDTH+1); busy is high for WIDTH+1 cycles (33 for WIDTH=32).
- Results:
  - mult/multu: {HI,LO} = full 2*WIDTH-bit signed/unsigned product.
  - madd: {HI,LO} ← {HI,LO} + signed product, mod 2^(2*WIDTH), using the HI/LO values at commit time.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Signed overflow (MIN_INT / -1): LO=MIN_INT, HI=0.
  - Divide by zero (div or divu): LO = all ones, HI = gpr_rs as latched. The engine still runs the full latency.
- mthi/mtlo (ops 5/6):
  - Write HI/LO from gpr_rs at the edge, only when Req=0 and state=IDLE; the start value is irrelevant.
  - Ignored while busy; the controller must stall them.
- start while busy: ignored; the operation in flight is not disturbed.
- Req=1 at any edge:
  - RUN/FIX is aborted to IDLE and busy=0 at that edge.
  - HI/LO keep their pre-op values; no partial commit.
  - start, mthi and mtlo are ignored that edge.
- Req=1 coinciding with FIX: the abort wins and nothing is committed.
- start arriving the edge after commit (back-to-back ops): accepted normally; madd sees the freshly committed HI/LO.
- Unused MDUOp with start=1 (0, 5, 6): no launch; 5/6 act as mthi/mtlo only.

Test Plan (WIDTH=32):
- mult rs=0xFFFFFFFE, rt=3 -> busy high exactly 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- divu 100/7 -> LO=14, HI=2. div rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- div and divu with rs=0x1234, rt=0 -> LO=0xFFFFFFFF, HI=0x1234 after 33 cycles.
- mthi 5, mtlo 7, then madd rs=-1, rt=2 -> HI=5, LO=5. mtlo issued while busy -> LO unchanged.
- mult started, Req pulsed at cycle 10 -> busy=0 the next cycle, HI/LO unchanged, no later commit. Repeat with Req at the FIX edge -> no commit.
- reset driven low at cycle 15 of a div (asynchronous, between edges) -> busy, HI and LO go to 0 immediately. After release, a fresh multu 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
